// File: rtl/flop_fifo_pkg.sv
// flop_fifo_pkg: shared defaults and width helper for the flip-flop FIFO
package flop_fifo_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int BITS_DEF = 16;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/flop_fifo_ptr.sv
// flop_fifo_ptr: wrapping pointer counter, 0..depth-1, async active-low reset
module flop_fifo_ptr
  import flop_fifo_pkg::*;
#(
  parameter int depth = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  output logic [clog2_min1(depth)-1:0] ptr
);
  localparam int PW = clog2_min1(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (inc) ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
endmodule

// File: rtl/flop_fifo.sv
// flop_fifo: FWFT synchronous FIFO on a register array with full/pndng flags.
// Define FLOP_FIFO_COUNT_EN to expose occupancy (count) and a sticky overflow flag (ovf).
module flop_fifo
  import flop_fifo_pkg::*;
#(
  parameter int depth = DEPTH_DEF,
  parameter int bits  = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
`ifdef FLOP_FIFO_COUNT_EN
  ,
  output logic [clog2_min1(depth+1)-1:0] count,
  output logic                           ovf
`endif
);
  localparam int PW = clog2_min1(depth);
  localparam int CW = clog2_min1(depth + 1);
  logic [PW-1:0] w_wr, w_rd;
  logic [CW-1:0] r_count;
  logic [bits-1:0] r_mem [depth];
  logic w_push_ok, w_pop_ok;
  assign full      = r_count == CW'(depth);
  assign pndng     = r_count != '0;
  // a pop frees the slot in the same edge, so a push is accepted even when full
  assign w_push_ok = push & (~full | pop);
  assign w_pop_ok  = pop & pndng;
  assign Dout      = pndng ? r_mem[w_rd] : '0;
  flop_fifo_ptr #(.depth(depth)) u_wr (.clk(clk), .rst(rst), .inc(w_push_ok), .ptr(w_wr));
  flop_fifo_ptr #(.depth(depth)) u_rd (.clk(clk), .rst(rst), .inc(w_pop_ok), .ptr(w_rd));
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    else if (w_push_ok) r_mem[w_wr] <= Din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_count <= '0;
    else if (w_push_ok != w_pop_ok) r_count <= w_push_ok ? r_count + CW'(1) : r_count - CW'(1);
`ifdef FLOP_FIFO_COUNT_EN
  logic r_ovf;
  assign count = r_count;
  assign ovf   = r_ovf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ovf <= 1'b0;
    else if (push & ~w_push_ok) r_ovf <= 1'b1;
`endif
endmodule

// File: tb/tb_flop_fifo.sv
// tb_flop_fifo: vector table, directed corner sequences and random traffic vs a queue model
module tb_flop_fifo;
  logic clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0;
  logic [15:0] din = '0, dout;
  logic full, pndng;
  int n_chk = 0, n_pass = 0;
  logic [15:0] q[$];
  flop_fifo #(.depth(8), .bits(16)) dut (
    .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop),
    .Dout(dout), .full(full), .pndng(pndng)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        push, pop;
    logic [15:0] din;
    logic        full, pndng;
    logic [15:0] dout;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic step(input logic p, input logic r, input logic [15:0] d, input string nm);
    bit pu, po;
    push = p; pop = r; din = d;
    @(posedge clk);
    #1;
    po = r && q.size() > 0;
    pu = p && (q.size() < 8 || r);
    if (po) void'(q.pop_front());
    if (pu) q.push_back(d);
    chk({nm, ".full"}, 32'(full), 32'(q.size() == 8));
    chk({nm, ".pndng"}, 32'(pndng), 32'(q.size() != 0));
    chk({nm, ".dout"}, 32'(dout), 32'(q.size() ? q[0] : 16'h0));
    push = 0; pop = 0;
  endtask
  initial begin
    vt[0] = '{1, 0, 16'h1234, 0, 1, 16'h1234};
    vt[1] = '{0, 1, 16'h0000, 0, 0, 16'h0000};
    vt[2] = '{0, 1, 16'h0000, 0, 0, 16'h0000};
    vt[3] = '{1, 1, 16'h0055, 0, 1, 16'h0055};
    vt[4] = '{1, 1, 16'h0066, 0, 1, 16'h0066};
    vt[5] = '{1, 0, 16'h0077, 0, 1, 16'h0066};
    vt[6] = '{0, 1, 16'h0000, 0, 1, 16'h0077};
    vt[7] = '{0, 1, 16'h0000, 0, 0, 16'h0000};
    push = 1; din = 16'hAAAA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.full", 32'(full), 0);
    chk("rst.pndng", 32'(pndng), 0);
    chk("rst.dout", 32'(dout), 0);
    push = 0; rst = 1;
    step(0, 0, 0, "post_rst");
    for (int i = 0; i < 8; i++) begin
      step(vt[i].push, vt[i].pop, vt[i].din, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_full", i), 32'(full), 32'(vt[i].full));
      chk($sformatf("vec%0d.tbl_pndng", i), 32'(pndng), 32'(vt[i].pndng));
      chk($sformatf("vec%0d.tbl_dout", i), 32'(dout), 32'(vt[i].dout));
    end
    for (int i = 1; i <= 8; i++) step(1, 0, 16'(i), "fill");
    chk("fill.full8", 32'(full), 1);
    step(1, 0, 16'h0009, "ovf_drop");
    chk("ovf.head", 32'(dout), 32'h0001);
    step(1, 1, 16'h00FF, "full_pushpop");
    chk("fpp.full", 32'(full), 1);
    chk("fpp.head", 32'(dout), 32'h0002);
    for (int i = 0; i < 7; i++) step(0, 1, 0, "drain");
    chk("drain.last", 32'(dout), 32'h00FF);
    step(0, 1, 0, "drain_end");
    chk("drain.empty", 32'(pndng), 0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) step(1, 0, 16'(16'h0100 + k * 3 + j), "wrap_push");
      for (int j = 0; j < 3; j++) begin
        chk("wrap.order", 32'(dout), 32'(16'h0100 + k * 3 + j));
        step(0, 1, 0, "wrap_pop");
      end
    end
    for (int i = 0; i < 5; i++) step(1, 0, 16'(16'hC000 + i), "pre_arst");
    #2 rst = 0;
    #1;
    chk("arst.pndng", 32'(pndng), 0);
    chk("arst.dout", 32'(dout), 0);
    chk("arst.full", 32'(full), 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1;
    step(0, 1, 0, "arst_pop_empty");
    step(1, 0, 16'hBEEF, "arst_push");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 16'($urandom), "rand");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/flop_fifo.md
Name: flop_fifo

Overview:
- Parameterized synchronous FIFO built from flip-flops (register array, no RAM macro).
- First-word-fall-through (FWFT): the head word is always visible on Dout.
- Status flags full and pndng (data pending).
- Sits between a producer (push/Din) and a consumer (pop/Dout) in the same clock domain.

Parameters:
- depth, 8, number of storage entries; integer >= 2; power of two not required.
- bits, 16, data word width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately).
- Din  input  bits  write data, sampled on a rising clk edge when push=1 is accepted.
- push  input  1  write request.
- pop  input  1  read request; consumes the word currently on Dout.
- Dout  output  bits  head-of-queue word; combinational from storage.
- full  output  1  high when occupancy == depth.
- pndng  output  1  high when occupancy > 0.

Behaviour:
- Storage: depth x bits register array; write pointer, read pointer, occupancy counter (0..depth).
- Pointer width is clog2(depth), minimum 1. Pointers wrap from depth-1 to 0 explicitly, not by natural overflow.
- Reset (rst=0, asynchronous):
  - pointers = 0, count = 0.
  - full = 0, pndng = 0, Dout = 0.
  - Array contents are cleared to 0.
  - Reset asserted mid-operation discards all stored data immediately, without waiting for a clock edge.
- Accept rules, evaluated each rising edge with rst=1:
  - push_ok = push & (~full | pop)
  - pop_ok = pop & pndng
- Write: on push_ok, mem[wr_ptr] <= Din; wr_ptr advances with wrap.
- Read: on pop_ok, rd_ptr advances with wrap.
- Count update:
  - +1 if push_ok & ~pop_ok
  - -1 if pop_ok & ~push_ok
  - unchanged otherwise
- Flags: full = (count == depth), pndng = (count != 0). Both are registered-state derived and settle in the same cycle the count changes.
- Dout:
  - When pndng=1, Dout = mem[rd_ptr].
  - When pndng=0, Dout = 0.
  - A word pushed at edge N appears on Dout after edge N (zero-latency FWFT) if the FIFO was empty.
- Boundary cases:
  - Push when full and no pop: the write is dropped, state unchanged, no error output.
  - Push+pop when full: both accepted, count stays at depth, full stays 1.
  - Pop when empty: ignored, pointers unchanged.
  - Push+pop when empty: only the push is accepted, count becomes 1, new word on Dout.
  - Push+pop with 0 < count < depth: both accepted, count unchanged, order preserved.
- Ordering: strict FIFO; no reordering or duplication.
- X on push/pop while rst=1 is not supported.

Optional Feature:
- Macro: FLOP_FIFO_COUNT_EN
- When defined:
  - Extra output port "count", clog2(depth+1) bits, equal to the current occupancy.
  - Extra output "ovf", 1 bit: sticky flag set when a push is dropped due to full.
  - ovf is cleared only by reset.
- When undefined: neither port exists; core behaviour is identical.

Decomposition:
- Package flop_fifo_pkg holds:
  - function clog2_min1(int) used for pointer and count widths.
  - localparam-style defaults DEPTH_DEF=8, BITS_DEF=16.
- One natural sub-module: flop_fifo_ptr.
  - Parameter depth; ports clk, rst, inc, ptr.
  - Wrapping pointer counter with async active-low reset.
  - Instantiated twice (write and read pointers).
- Storage array, count and flags live in flop_fifo.

Test Plan:
- Reset: hold rst=0 for 2 cycles with push=1, Din=16'hAAAA -> full=0, pndng=0, Dout=0; no word stored after release.
- Single word: push Din=16'h1234 for one cycle -> next cycle pndng=1, Dout=16'h1234; pop one cycle -> pndng=0, Dout=0.
- Fill and overflow: push 16'h0001..16'h0008 (8 words) -> full=1 after the 8th; push 16'h0009 -> dropped. Pop 8 times -> Dout sequence 0001..0008, then pndng=0.
- Simultaneous push/pop when full: with 8 words stored, push=1, pop=1, Din=16'h00FF -> full stays 1; Dout advances to the second word; 16'h00FF emerges 8th after further pops.
- Wrap-around: repeat push 3 / pop 3 cycles x5 with incrementing data -> all 15 words read in order; pointers wrap past 7 without corruption.
- Async reset mid-stream: 5 words stored, drop rst low between clock edges -> pndng=0, Dout=0 immediately, before the next rising edge.
